// File: rtl/det_stream_arbiter.sv
// rtl/det_stream_arbiter.sv - round-robin share of one serial pattern detector between two word requesters
module det_stream_arbiter #(
    parameter int W       = 8,
    parameter int CW      = 4,
    parameter int DET_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  data0,
    input  logic [W-1:0]  data1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          det_rst,
    output logic          det_in,
    input  logic          det_out,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] match_cnt
);

    localparam int KMAX = W + DET_LAT;
    localparam int KW   = $clog2(KMAX + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sr;
    logic          cur_id;
    logic          last_id;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pick1;
    logic          hit;

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        det_rst   = !reset;
        det_in    = 1'b0;
        done      = 1'b0;
        // requester 1 wins alone, or on a tie when requester 0 was served last
        pick1     = req1 && (!req0 || !last_id);
        case (state)
            IDLE: begin
                if (reset && (req0 || req1)) begin
                    gnt0      = !pick1;
                    gnt1      = pick1;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                det_rst   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                det_in = reset & sr[W-1];
                if (k == KW'(W - 1))
                    state_nxt = (DET_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (k == KW'(KMAX - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = reset;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // only count flags that belong to bits of this word, skipping the detector latency
        hit     = (state == SHIFT || state == DRAIN) && det_out && (k >= KW'(DET_LAT));
        cnt_nxt = cnt + CW'(hit);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            cur_id    <= 1'b0;
            last_id   <= 1'b1;
            k         <= '0;
            cnt       <= '0;
            done_id   <= 1'b0;
            match_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                sr      <= gnt1 ? data1 : data0;
                cur_id  <= gnt1;
                last_id <= gnt1;
            end
            if (state == CLR) begin
                k   <= '0;
                cnt <= '0;
            end else if (state == SHIFT || state == DRAIN) begin
                k   <= k + KW'(1);
                cnt <= cnt_nxt;
                if (state == SHIFT)
                    sr <= {sr[W-2:0], 1'b0};
            end
            // results are published on entry to DONE and held until the next one
            if (state_nxt == DONE && state != DONE) begin
                done_id   <= cur_id;
                match_cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: doc/det_stream_arbiter.md
# det_stream_arbiter

Controller that shares one serial pattern-detector FSM between two parallel-word requesters. It arbitrates requests round-robin, clears the detector, shifts the granted word MSB-first into it, and counts the cycles in which the detector flags a match. It reports one match count per word, tagged with the requester ID. It sits between two word-producing clients and the bit-serial detector (`in`/`out`-style datapath).

## Interface
- `W`, 8: word width, i.e. serial bits per transaction.
- `CW`, 4: match-count width; must satisfy 2^CW ≥ W+1.
- `DET_LAT`, 1: cycles from a bit driven on `det_in` to its result on `det_out`; 0 allowed for a Mealy detector.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0`, `req1`  in  1  request; held high with data stable until the matching grant is sampled.
- `data0`, `data1`  in  W  word to scan.
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse; data is captured on that edge.
- `det_rst`  out  1  active-high clear to the detector.
- `det_in`  out  1  serial bit to the detector.
- `det_out`  in  1  detector match flag.
- `done`  out  1  one-cycle pulse: result valid.
- `done_id`  out  1  requester of the finished word (0/1).
- `match_cnt`  out  CW  number of `det_out`-high cycles in the scan window.

## Operation
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Request present: pick a winner by round-robin. The requester not granted last wins on a tie. After reset, `req0` has priority.
  - Assert the winner's grant combinationally. Load its data into the shift register, record its ID, update the pointer, then go to CLR.
- CLR: `det_rst`=1 and `det_in`=0 for one cycle. Clear the bit counter k and the match counter. Go to SHIFT.
- SHIFT: W cycles, k=0..W-1. `det_in` = shift-register MSB; the register shifts left each cycle. Go to DRAIN, or to DONE directly if `DET_LAT`=0.
- DRAIN: `DET_LAT` cycles. `det_in`=0. k continues W..W+DET_LAT-1.
- Match counting: across SHIFT+DRAIN, increment the match counter when `det_out`=1 and DET_LAT ≤ k ≤ W+DET_LAT-1. Other cycles are ignored.
- Counter width: max count is W, so no overflow for legal `CW`.
- DONE: `done`=1 for one cycle. `done_id` and `match_cnt` update in this cycle and hold until the next DONE. Return to IDLE.
- Requests arriving during a transaction wait; no preemption. A request dropped before its grant is simply not served.
- `gnt0` and `gnt1` are never high together. Each grant is followed by exactly one `done` unless reset intervenes.

## Timing
- Grant sampled at cycle T (IDLE): CLR at T+1, SHIFT at T+2..T+W+1, DRAIN at T+W+2..T+W+DET_LAT+1, DONE at T+W+DET_LAT+2.
- Latency from grant to `done` is W+DET_LAT+2 cycles. With defaults: 11.
- Minimum grant-to-grant spacing is W+DET_LAT+3 cycles. With defaults: 12.
- Reset (`reset`=0 at an edge):
  - State goes to IDLE and the pointer returns to `req0` priority.
  - `gnt0`=`gnt1`=0, `det_in`=0, `done`=0, `done_id`=0, `match_cnt`=0.
  - `det_rst`=1 for every cycle `reset` is low.
- Reset mid-transaction aborts it: no `done`, the result is discarded, and the requester must re-request.
- Reset dominates a request in the same cycle: no grant.

## Test plan
Bench detector model: overlapping "1001" Moore detector, `DET_LAT`=1, W=8.
- Reset held low for 3 cycles with both requests high → no grants; `det_rst`=1 throughout; all other outputs 0.
- `req0`, `data0`=8'b1001_0010 → `gnt0` one cycle at T; `det_in` = 1,0,0,1,0,0,1,0 on T+2..T+9; `done` at T+11 with `done_id`=0, `match_cnt`=2.
- `req0` and `req1` raised together after reset, both held → grants go 0,1,0,1, 12 cycles apart; `done_id` alternates 0,1,0,1.
- `req1`, 8'hFF → `match_cnt`=0. Then `req1`, 8'b1001_1001 → `match_cnt`=2. Between the two `done` pulses, `match_cnt` holds 0.
- `reset` low at T+5 during SHIFT → no `done`; IDLE next cycle. A new `req1` 8'b0001_0011 completes with `match_cnt`=1 and `done_id`=1.
- `req0` dropped before its grant while `req1` is held → only `gnt1` ever fires; no spurious `done`.
